// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Operation codes follow funct3 of the OP/funct7=0000001 group.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_div(muldiv_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step: add-shift for multiply, restoring subtract-shift
// for divide. acc is the high/remainder half, mq the multiplier/quotient.
module muldiv_step #(
    parameter int W = 32
) (
    input  logic         div_mode,
    input  logic [W-1:0] operand,
    input  logic [W-1:0] acc,
    input  logic [W-1:0] mq,
    output logic [W-1:0] acc_next,
    output logic [W-1:0] mq_next
);

    logic [W:0] sum;
    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
        shifted = {acc, mq[W-1]};
        diff    = shifted - {1'b0, operand};
        if (div_mode) begin
            // Remainder stays below the divisor, so diff[W] is a clean borrow.
            if (!diff[W]) begin
                acc_next = diff[W-1:0];
                mq_next  = {mq[W-2:0], 1'b1};
            end else begin
                acc_next = shifted[W-1:0];
                mq_next  = {mq[W-2:0], 1'b0};
            end
        end else begin
            acc_next = sum[W:1];
            mq_next  = {sum[0], mq[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/done handshake.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] src_a_i,
    input  logic [DATA_WIDTH-1:0] src_b_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int W    = DATA_WIDTH;
    localparam int S    = STEPS_PER_CYCLE;
    localparam int ITER = W / S;
    localparam int CW   = $clog2(ITER + 1);

    muldiv_state_t state;
    muldiv_op_t    op_q;
    logic          neg_q;
    logic          done_q;
    logic [W-1:0]  operand_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  mq_q;
    logic [W-1:0]  res_q;
    logic [CW-1:0] cnt_q;

    muldiv_op_t   op_in;
    logic         div_in;
    logic         rem_in;
    logic         sgn_a;
    logic         sgn_b;
    logic         sa;
    logic         sb;
    logic         neg_in;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;
    logic         div_zero;
    logic         div_ovf;
    logic         fast_mul;
    logic         fast;
    logic [W-1:0] fast_mul_res;
    logic [W-1:0] fast_res;

    assign op_in  = muldiv_op_t'(op_i);
    assign div_in = is_div(op_in);
    assign rem_in = div_in & op_i[1];

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        unique case (op_in)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            OP_MULHSU: sgn_a = 1'b1;
            default: begin
            end
        endcase
    end

    assign sa     = sgn_a & src_a_i[W-1];
    assign sb     = sgn_b & src_b_i[W-1];
    assign mag_a  = sa ? -src_a_i : src_a_i;
    assign mag_b  = sb ? -src_b_i : src_b_i;
    assign neg_in = rem_in ? sa : (sa ^ sb);

    assign div_zero = div_in & (src_b_i == '0);
    assign div_ovf  = div_in & sgn_a
                    & (src_a_i == {1'b1, {(W-1){1'b0}}})
                    & (&src_b_i);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*W-1:0] fa;
    logic signed [2*W-1:0] fb;
    logic signed [2*W-1:0] fp;

    // (W+1)-bit signed operands, extended so the product is exact mod 2^2W.
    assign fa           = {{W{sa}}, src_a_i};
    assign fb           = {{W{sb}}, src_b_i};
    assign fp           = fa * fb;
    assign fast_mul     = ~div_in;
    assign fast_mul_res = (op_in == OP_MUL) ? fp[W-1:0] : fp[2*W-1:W];
`else
    assign fast_mul     = 1'b0;
    assign fast_mul_res = '0;
`endif

    assign fast = div_zero | div_ovf | fast_mul;

    always_comb begin
        if (fast_mul)
            fast_res = fast_mul_res;
        else if (div_zero)
            fast_res = rem_in ? src_a_i : '1;
        else
            fast_res = rem_in ? '0 : src_a_i;
    end

    logic [W-1:0]   acc_c [S+1];
    logic [W-1:0]   mq_c  [S+1];
    logic           div_q;
    logic [2*W-1:0] prod_mag;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem_s;
    logic [W-1:0]   calc_res;

    assign div_q    = is_div(op_q);
    assign acc_c[0] = acc_q;
    assign mq_c[0]  = mq_q;

    for (genvar g = 0; g < S; g++) begin : g_step
        muldiv_step #(.W(W)) u_step (
            .div_mode (div_q),
            .operand  (operand_q),
            .acc      (acc_c[g]),
            .mq       (mq_c[g]),
            .acc_next (acc_c[g+1]),
            .mq_next  (mq_c[g+1])
        );
    end

    assign prod_mag = {acc_c[S], mq_c[S]};
    assign prod     = neg_q ? -prod_mag : prod_mag;
    assign quo      = neg_q ? -mq_c[S] : mq_c[S];
    assign rem_s    = neg_q ? -acc_c[S] : acc_c[S];

    always_comb begin
        if (div_q)
            calc_res = op_q[1] ? rem_s : quo;
        else if (op_q == OP_MUL)
            calc_res = prod[W-1:0];
        else
            calc_res = prod[2*W-1:W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            operand_q <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: if (start_i) begin
                        op_q      <= op_in;
                        neg_q     <= neg_in;
                        operand_q <= div_in ? mag_b : mag_a;
                        mq_q      <= div_in ? mag_a : mag_b;
                        acc_q     <= '0;
                        cnt_q     <= CW'(ITER);
                        if (fast) begin
                            res_q  <= fast_res;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        acc_q <= acc_c[S];
                        mq_q  <= mq_c[S];
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            res_q  <= calc_res;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ready_o  = (state == IDLE);
    assign busy_o   = (state != IDLE);
    assign done_o   = done_q;
    assign result_o = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against
// a behavioural model, and hand sequences for flush/reset/busy cases.
module tb_muldiv_unit;

    localparam int W     = 32;
    localparam int STEPS = 1;
    localparam int IT    = W / STEPS;
    localparam int DL    = IT + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int ML    = 1;
`else
    localparam int ML    = IT + 1;
`endif

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
        int           poke;
        bit           poke_done;
    } vec_t;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         start_i = 1'b0;
    logic         flush_i = 1'b0;
    logic [2:0]   op_i    = '0;
    logic [W-1:0] src_a_i = '0;
    logic [W-1:0] src_b_i = '0;
    logic         ready_o;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;

    int           checks   = 0;
    int           errors   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res = '0;
    vec_t         tbl[$];

    always #5 clk = ~clk;

    muldiv_unit #(
        .DATA_WIDTH      (W),
        .STEPS_PER_CYCLE (STEPS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .src_a_i  (src_a_i),
        .src_b_i  (src_b_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(logic [2:0] op,
                                               logic [W-1:0] a,
                                               logic [W-1:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [63:0] ub64;
        logic signed [63:0] p;
        logic        [63:0] pu;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ub64 = {32'b0, b};
        case (op)
            3'd0: begin p = sa64 * sb64; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin
                pu = {32'b0, a} * {32'b0, b};
                return pu[63:32];
            end
            3'd4: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == '1) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == '1) return '0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(logic [2:0] op, logic [W-1:0] a,
                                  logic [W-1:0] b);
        if (op[2] && (b == 0 ||
            (!op[0] && a == 32'h8000_0000 && b == '1)))
            return 1;
        return op[2] ? DL : ML;
    endfunction

    // Result scoreboard: every done_o pops one expectation.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result_o=%h, none expected",
                         result_o);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("result", result_o, e);
                last_res = e;
            end
        end
    end

    task automatic run_op(input vec_t v);
        int n;
        bit got;
        @(negedge clk);
        op_i    = v.op;
        src_a_i = v.a;
        src_b_i = v.b;
        start_i = 1'b1;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1 start_i = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < v.lat + 8) begin
            @(negedge clk);
            n++;
            if (done_o) begin
                got = 1'b1;
            end else if (n == v.poke) begin
                chk("busy_when_poked", {31'b0, busy_o}, 32'd1);
                chk("ready_when_poked", {31'b0, ready_o}, 32'd0);
                op_i    = 3'b000;
                src_a_i = 32'd3;
                src_b_i = 32'd3;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: op %0d no done_o within %0d cycles",
                     v.op, v.lat + 8);
            if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
            start_i = 1'b0;
            return;
        end
        chk("latency", 32'(n), 32'(v.lat));
        if (v.poke_done) begin
            op_i    = 3'b000;
            src_a_i = 32'd3;
            src_b_i = 32'd3;
            start_i = 1'b1;
        end
        @(negedge clk);
        start_i = 1'b0;
        chk("done_single_pulse", {31'b0, done_o}, 32'd0);
        chk("ready_after_done", {31'b0, ready_o}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML, 0, 1'b1});
        tbl.push_back('{3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, ML, 0, 1'b0});
        tbl.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML, 0, 1'b0});
        tbl.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML, 0, 1'b0});
        tbl.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0, ML, 0, 1'b0});
        tbl.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML, 0, 1'b0});
        tbl.push_back('{3'd2, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, ML, 0, 1'b0});
        tbl.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, ML, 0, 1'b0});
        tbl.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DL, 0, 1'b0});
        tbl.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DL, 0, 1'b0});
        tbl.push_back('{3'd5, 32'd100, 32'd7, 32'd14, DL, 5, 1'b0});
        tbl.push_back('{3'd7, 32'd100, 32'd7, 32'd2, DL, 0, 1'b1});
        tbl.push_back('{3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DL, 0, 1'b0});
        tbl.push_back('{3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, DL, 0, 1'b0});
        tbl.push_back('{3'd4, 32'h8000_0000, 32'd1, 32'h8000_0000, DL, 0, 1'b0});
        tbl.push_back('{3'd7, 32'hFFFF_FFFF, 32'h10, 32'hF, DL, 0, 1'b0});
        tbl.push_back('{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0});
        tbl.push_back('{3'd6, 32'd5, 32'd0, 32'd5, 1, 0, 1'b0});
        tbl.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0});
        tbl.push_back('{3'd7, 32'd5, 32'd0, 32'd5, 1, 0, 1'b0});
        tbl.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b1});
        tbl.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, 1'b0});

        repeat (3) @(negedge clk);
        chk("reset_ready", {31'b0, ready_o}, 32'd1);
        chk("reset_busy", {31'b0, busy_o}, 32'd0);
        chk("reset_done", {31'b0, done_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) run_op(tbl[i]);

        for (int i = 0; i < 24; i++) begin
            vec_t v;
            v.op   = 3'($urandom_range(0, 7));
            v.a    = $urandom;
            v.b    = ($urandom_range(0, 2) == 0) ?
                     32'($urandom_range(0, 9)) : $urandom;
            v.exp  = ref_model(v.op, v.a, v.b);
            v.lat  = lat_of(v.op, v.a, v.b);
            v.poke = 0;
            v.poke_done = 1'b0;
            run_op(v);
        end

        // Flush mid-divide: no done, back to idle next cycle.
        @(negedge clk);
        op_i = 3'd5; src_a_i = 32'd100; src_b_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 10) flush_i = 1'b1;
            if (k == 11) begin
                flush_i = 1'b0;
                chk("flush_ready", {31'b0, ready_o}, 32'd1);
                chk("flush_busy", {31'b0, busy_o}, 32'd0);
                chk("flush_done", {31'b0, done_o}, 32'd0);
            end
        end
        repeat (IT + 4) @(negedge clk);
        chk("flush_result_held", result_o, last_res);

        // Flush and start together in idle: nothing accepted.
        @(negedge clk);
        op_i = 3'd4; src_a_i = 32'd5; src_b_i = 32'd0;
        start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush_start_ready", {31'b0, ready_o}, 32'd1);
        chk("flush_start_done", {31'b0, done_o}, 32'd0);
        repeat (IT + 4) @(negedge clk);
        chk("flush_start_result", result_o, last_res);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        op_i = 3'd3; src_a_i = '1; src_b_i = '1; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_mid_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_mid_done", {31'b0, done_o}, 32'd0);
        chk("rst_mid_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (IT + 4) @(negedge clk);
        chk("rst_mid_result_after", result_o, 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
